dom_shared_mulxorsqsc_lanes: RTL and testbench
==============================================

Name: dom_shared_mulxorsqsc_lanes

Overview:
- Masked (DOM-indep) GF(2^2) datapath computing Q = X·B ⊕ sqsc(X ⊕ B) per lane, on SHARES Boolean shares.
- LANES independent GF(2^2) lanes side by side (LANES=2 covers one GF(2^4) operand pair).
- Used in the inverter stage of the shared AES S-box.
- Successor to the single-lane, fixed-latency variant: adds lane count, a valid-qualified pipeline with hold, and an optional output register.

Parameters:
- SHARES, 2, number of shares (d+1); legal 2..5.
- LANES, 2, number of parallel GF(2^2) lanes; legal 1..8.
- PIPELINED, 1, 1 = inner-domain terms registered; 0 = inner-domain terms combinational to output.
- Derived NPAIRS = SHARES*(SHARES-1)/2.

Ports:
- ClkxCI  in  1  clock.
- RstxBI  in  1  asynchronous active-low reset.
- ValidxSI  in  1  input shares and randomness valid this cycle.
- _XxDI  in  2*LANES*SHARES  X shares; lane l of share s at [(s*LANES+l)*2 +: 2].
- _BxDI  in  2*LANES*SHARES  B shares; same packing as _XxDI.
- _ZxDI  in  2*LANES*NPAIRS  fresh randomness; pair p of lane l at [(l*NPAIRS+p)*2 +: 2].
- ValidxSO  out  1  output shares valid.
- _QxDO  out  2*LANES*SHARES  Q shares; same packing as _XxDI.

Behaviour:
- Field: GF(2^2), normal basis {W, W^2}; bit1 = coefficient of W, bit0 = coefficient of W^2.
- mul(a,b): e = (a1⊕a0)(b1⊕b0); p1 = a1b1⊕e; p0 = a0b0⊕e.
- sqsc(a) = {a1⊕a0, a0}. This function is linear and is applied share-wise.
- Pair index for i<j: p = i*SHARES - i*(i+1)/2 + (j-i-1).
- Cross term C_ij = mul(X_i, B_j) ⊕ Z_p for i<j; C_ji = mul(X_j, B_i) ⊕ Z_p. Both use the same Z_p.
- Cross terms are always registered, one register per (i,j,lane). This register is the glitch barrier and is never removable.
- Inner term I_i = mul(X_i, B_i) ⊕ sqsc(X_i ⊕ B_i).
  - PIPELINED=1: I_i is registered.
  - PIPELINED=0: I_i is combinational; inputs must then be held constant one cycle after the valid cycle.
- Q_i = I_i ⊕ (XOR over j≠i of C_ij registered).
- Register update:
  - All datapath registers load only when ValidxSI=1, otherwise they hold.
  - ValidxSO register loads ValidxSI every cycle.
- Latency: 1 cycle; ValidxSO = ValidxSI delayed by 1.
- Back-to-back valid inputs give one result per cycle.
- When ValidxSI drops, _QxDO holds the last result (PIPELINED=1) and ValidxSO=0.
- Reset (asynchronous, any time, including mid-stream):
  - All registers clear to 0, so ValidxSO=0 and _QxDO=0.
  - First valid input after release yields ValidxSO=1 one cycle later.
- Randomness is consumed only on valid cycles. The bench must supply fresh Z per valid cycle.
- Unshared result XOR_s Q_s is independent of Z and of the share split.

Optional Feature:
- Macro DOM_MULXSQSC_OUTREG_EN.
- Defined: extra output register stage on _QxDO and ValidxSO, gated by the stage-1 valid.
  - Latency becomes 2 cycles; outputs glitch-free registers.
  - Reset clears this stage to 0.
- Undefined: latency 1; output is the XOR of registers.

Decomposition:
- Package dom_gf_pkg:
  - gf2 element typedef (logic [1:0]).
  - Functions gf2_mul, gf2_sqsc and pair_idx(i,j,SHARES).
  - Constant LATENCY per macro.
- One sub-module, dom_gf2_lane: a single lane with all shares, instantiated LANES times by generate.
- Top level holds the valid pipeline and the packing.

Test Plan:
- SHARES=2, LANES=1, X=01, B=01, random split and Z → unshared Q=10 one cycle after valid; ValidxSO pulses 1 cycle.
- X=11, B=10 → Q=01. X=00, B=11 → Q=01. X=10, B=10 → Q=01. All 16 (X,B) pairs × all share splits checked against the reference model.
- LANES=2, SHARES=3, back-to-back valid stream of 64 random operands → one correct result per cycle; lanes independent (e.g. lane0 X=01,B=01 → 10; lane1 X=11,B=10 → 01).
- Valid high 1 cycle then low 5 cycles with inputs toggling → _QxDO holds the result, ValidxSO=0 for those cycles.
- Assert RstxBI=0 mid-stream between clock edges → _QxDO=0 and ValidxSO=0 immediately; after release, first valid gives a correct result at latency 1 (2 with DOM_MULXSQSC_OUTREG_EN).
- Same operands with two different Z vectors → identical unshared Q, differing individual shares.

Source files
------------

// File: rtl/dom_gf_pkg.sv
// GF(2^2) helpers (normal basis {W, W^2}) shared by the DOM mul-xor-sqsc gadget.
// DOM_MULXSQSC_OUTREG_EN selects the extra output register stage (LATENCY 2).
package dom_gf_pkg;

    typedef logic [1:0] gf2_t;

`ifdef DOM_MULXSQSC_OUTREG_EN
    localparam int LATENCY = 2;
`else
    localparam int LATENCY = 1;
`endif

    // bit1 = coefficient of W, bit0 = coefficient of W^2
    function automatic gf2_t gf2_mul(input gf2_t a, input gf2_t b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

    function automatic gf2_t gf2_sqsc(input gf2_t a);
        return {a[1] ^ a[0], a[0]};
    endfunction

    // Index of the unordered share pair (i,j), i<j
    function automatic int pair_idx(input int i, input int j, input int shares);
        return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/dom_gf2_lane.sv
// One GF(2^2) lane of the DOM-indep Q = X*B ^ sqsc(X^B) gadget across all shares.
// Cross-domain products are always registered; inner terms registered when PIPELINED=1.
module dom_gf2_lane
    import dom_gf_pkg::*;
#(
    parameter  int SHARES    = 2,
    parameter  int PIPELINED = 1,
    localparam int NPAIRS    = SHARES * (SHARES - 1) / 2
) (
    input  logic                ClkxCI,
    input  logic                RstxBI,
    input  logic                EnxSI,
    input  logic [2*SHARES-1:0] XxDI,
    input  logic [2*SHARES-1:0] BxDI,
    input  logic [2*NPAIRS-1:0] ZxDI,
    output logic [2*SHARES-1:0] QxDO
);

    gf2_t x_s        [SHARES];
    gf2_t b_s        [SHARES];
    gf2_t inner_comb [SHARES];
    gf2_t inner_use  [SHARES];
    gf2_t z_p        [NPAIRS];

    // Slot 2p holds C_ij (belongs to share i), slot 2p+1 holds C_ji (share j)
    gf2_t cross_d    [2*NPAIRS];
    gf2_t cross_q    [2*NPAIRS];

    always_comb begin
        for (int s = 0; s < SHARES; s++) begin
            x_s[s]        = XxDI[2*s +: 2];
            b_s[s]        = BxDI[2*s +: 2];
            inner_comb[s] = gf2_mul(XxDI[2*s +: 2], BxDI[2*s +: 2])
                          ^ gf2_sqsc(XxDI[2*s +: 2] ^ BxDI[2*s +: 2]);
        end
        for (int p = 0; p < NPAIRS; p++) begin
            z_p[p] = ZxDI[2*p +: 2];
        end
    end

    always_comb begin
        int p;
        p = 0;
        for (int k = 0; k < 2*NPAIRS; k++) begin
            cross_d[k] = cross_q[k];
        end
        if (EnxSI) begin
            for (int i = 0; i < SHARES; i++) begin
                for (int j = i + 1; j < SHARES; j++) begin
                    p              = pair_idx(i, j, SHARES);
                    cross_d[2*p]   = gf2_mul(x_s[i], b_s[j]) ^ z_p[p];
                    cross_d[2*p+1] = gf2_mul(x_s[j], b_s[i]) ^ z_p[p];
                end
            end
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            for (int k = 0; k < 2*NPAIRS; k++) begin
                cross_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2*NPAIRS; k++) begin
                cross_q[k] <= cross_d[k];
            end
        end
    end

    generate
        if (PIPELINED != 0) begin : g_inner_reg
            gf2_t inner_d [SHARES];
            gf2_t inner_q [SHARES];

            always_comb begin
                for (int s = 0; s < SHARES; s++) begin
                    inner_d[s]   = EnxSI ? inner_comb[s] : inner_q[s];
                    inner_use[s] = inner_q[s];
                end
            end

            always_ff @(posedge ClkxCI or negedge RstxBI) begin
                if (!RstxBI) begin
                    for (int s = 0; s < SHARES; s++) begin
                        inner_q[s] <= '0;
                    end
                end else begin
                    for (int s = 0; s < SHARES; s++) begin
                        inner_q[s] <= inner_d[s];
                    end
                end
            end
        end else begin : g_inner_comb
            // Inputs must stay stable for the cycle after the valid cycle
            always_comb begin
                for (int s = 0; s < SHARES; s++) begin
                    inner_use[s] = inner_comb[s];
                end
            end
        end
    endgenerate

    always_comb begin
        gf2_t q_acc [SHARES];
        int   p;
        p = 0;
        for (int s = 0; s < SHARES; s++) begin
            q_acc[s] = inner_use[s];
        end
        for (int i = 0; i < SHARES; i++) begin
            for (int j = i + 1; j < SHARES; j++) begin
                p        = pair_idx(i, j, SHARES);
                q_acc[i] = q_acc[i] ^ cross_q[2*p];
                q_acc[j] = q_acc[j] ^ cross_q[2*p+1];
            end
        end
        QxDO = '0;
        for (int s = 0; s < SHARES; s++) begin
            QxDO[2*s +: 2] = q_acc[s];
        end
    end

endmodule

// File: rtl/dom_shared_mulxorsqsc_lanes.sv
// LANES-wide masked GF(2^2) Q = X*B ^ sqsc(X^B) with valid pipeline and share packing.
// Define DOM_MULXSQSC_OUTREG_EN for a registered, glitch-free output stage (latency 2).
module dom_shared_mulxorsqsc_lanes
    import dom_gf_pkg::*;
#(
    parameter  int SHARES    = 2,
    parameter  int LANES     = 2,
    parameter  int PIPELINED = 1,
    localparam int NPAIRS    = SHARES * (SHARES - 1) / 2
) (
    input  logic                        ClkxCI,
    input  logic                        RstxBI,
    input  logic                        ValidxSI,
    input  logic [2*LANES*SHARES-1:0]   _XxDI,
    input  logic [2*LANES*SHARES-1:0]   _BxDI,
    input  logic [2*LANES*NPAIRS-1:0]   _ZxDI,
    output logic                        ValidxSO,
    output logic [2*LANES*SHARES-1:0]   _QxDO
);

    logic [LANES-1:0][2*SHARES-1:0] lane_x;
    logic [LANES-1:0][2*SHARES-1:0] lane_b;
    logic [LANES-1:0][2*SHARES-1:0] lane_q;
    logic [2*LANES*SHARES-1:0]      q_stage1;
    logic                           valid_d;
    logic                           valid_q;

    // Bus is share-major; each lane instance wants its shares contiguous
    always_comb begin
        lane_x = '0;
        lane_b = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < SHARES; s++) begin
                lane_x[l][2*s +: 2] = _XxDI[(s*LANES+l)*2 +: 2];
                lane_b[l][2*s +: 2] = _BxDI[(s*LANES+l)*2 +: 2];
            end
        end
    end

    always_comb begin
        q_stage1 = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < SHARES; s++) begin
                q_stage1[(s*LANES+l)*2 +: 2] = lane_q[l][2*s +: 2];
            end
        end
    end

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            dom_gf2_lane #(
                .SHARES    (SHARES),
                .PIPELINED (PIPELINED)
            ) u_lane (
                .ClkxCI (ClkxCI),
                .RstxBI (RstxBI),
                .EnxSI  (ValidxSI),
                .XxDI   (lane_x[l]),
                .BxDI   (lane_b[l]),
                .ZxDI   (_ZxDI[l*2*NPAIRS +: 2*NPAIRS]),
                .QxDO   (lane_q[l])
            );
        end
    endgenerate

    always_comb begin
        valid_d = ValidxSI;
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

`ifdef DOM_MULXSQSC_OUTREG_EN
    logic [2*LANES*SHARES-1:0] qout_d;
    logic [2*LANES*SHARES-1:0] qout_q;
    logic                      vout_d;
    logic                      vout_q;

    always_comb begin
        vout_d = valid_q;
        qout_d = valid_q ? q_stage1 : qout_q;
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            vout_q <= 1'b0;
            qout_q <= '0;
        end else begin
            vout_q <= vout_d;
            qout_q <= qout_d;
        end
    end

    assign ValidxSO = vout_q;
    assign _QxDO    = qout_q;
`else
    assign ValidxSO = valid_q;
    assign _QxDO    = q_stage1;
`endif

endmodule

// File: tb/tb_dom_shared_mulxorsqsc_lanes.sv
// Bench for dom_shared_mulxorsqsc_lanes: 2-share/1-lane and 3-share/2-lane instances
// checked against a log/antilog GF(4) model of the unshared result.
module tb_dom_shared_mulxorsqsc_lanes;
    import dom_gf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        va, vao;
    logic [3:0]  xa, ba, qa;
    logic [1:0]  za;
    logic        vb, vbo;
    logic [11:0] xb, bb, zb, qb;

    int n_pass  = 0;
    int n_total = 0;

    dom_shared_mulxorsqsc_lanes #(.SHARES(2), .LANES(1), .PIPELINED(1)) u_a (
        .ClkxCI(clk), .RstxBI(rst_n), .ValidxSI(va),
        ._XxDI(xa), ._BxDI(ba), ._ZxDI(za),
        .ValidxSO(vao), ._QxDO(qa)
    );

    dom_shared_mulxorsqsc_lanes #(.SHARES(3), .LANES(2), .PIPELINED(1)) u_b (
        .ClkxCI(clk), .RstxBI(rst_n), .ValidxSI(vb),
        ._XxDI(xb), ._BxDI(bb), ._ZxDI(zb),
        .ValidxSO(vbo), ._QxDO(qb)
    );

    // GF(4) as {0} U {W^k}: 11 = 1 = W^0, 10 = W, 01 = W^2
    function automatic int gf_log(input logic [1:0] a);
        case (a)
            2'b11:   return 0;
            2'b10:   return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [1:0] gf_exp(input int k);
        case (k % 3)
            0:       return 2'b11;
            1:       return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] ref_mul(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'b00 || b == 2'b00) return 2'b00;
        return gf_exp(gf_log(a) + gf_log(b));
    endfunction

    // square then scale by W^2
    function automatic logic [1:0] ref_sqsc(input logic [1:0] a);
        if (a == 2'b00) return 2'b00;
        return gf_exp(2 * gf_log(a) + 2);
    endfunction

    function automatic logic [1:0] ref_q(input logic [1:0] x, input logic [1:0] b);
        return ref_mul(x, b) ^ ref_sqsc(x ^ b);
    endfunction

    function automatic logic [11:0] pack_b(input logic [1:0] v0, input logic [1:0] v1);
        logic [11:0] r;
        logic [1:0]  v;
        r = 12'($urandom);
        for (int l = 0; l < 2; l++) begin
            v = (l == 0) ? v0 : v1;
            r[(4+l)*2 +: 2] = v ^ r[l*2 +: 2] ^ r[(2+l)*2 +: 2];
        end
        return r;
    endfunction

    function automatic logic [1:0] unsh_b(input logic [11:0] bus, input int l);
        logic [1:0] acc;
        acc = 2'b00;
        for (int s = 0; s < 3; s++) acc = acc ^ bus[(s*2+l)*2 +: 2];
        return acc;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [1:0] x, input logic [1:0] b,
                           input logic [1:0] rx, input logic [1:0] rb,
                           output logic [1:0] q_un, output logic v_out);
        xa = {x ^ rx, rx};
        ba = {b ^ rb, rb};
        za = 2'($urandom);
        va = 1'b1;
        tick();
        va = 1'b0;
        for (int i = 1; i < LATENCY; i++) tick();
        v_out = vao;
        q_un  = qa[1:0] ^ qa[3:2];
    endtask

    task automatic pulse_b(output logic [3:0] q_un, output logic v_out);
        vb = 1'b1;
        tick();
        vb = 1'b0;
        for (int i = 1; i < LATENCY; i++) tick();
        v_out = vbo;
        q_un  = {unsh_b(qb, 1), unsh_b(qb, 0)};
    endtask

    typedef struct {
        logic [1:0] x;
        logic [1:0] b;
        logic [1:0] q;
    } vec_t;

    vec_t        tbl [4];
    logic [1:0]  qun;
    logic [3:0]  qun_b, qun_b2;
    logic        vo;
    logic [3:0]  held_a;
    logic [11:0] q1, q2, z1;
    logic [3:0]  expq [$];
    logic [3:0]  e;
    logic [1:0]  x0, b0, x1, b1;
    int          got;

    initial begin
        tbl[0] = '{x: 2'b01, b: 2'b01, q: 2'b10};
        tbl[1] = '{x: 2'b11, b: 2'b10, q: 2'b01};
        tbl[2] = '{x: 2'b00, b: 2'b11, q: 2'b01};
        tbl[3] = '{x: 2'b10, b: 2'b10, q: 2'b01};

        rst_n = 1'b0;
        va = 1'b0; xa = '0; ba = '0; za = '0;
        vb = 1'b0; xb = '0; bb = '0; zb = '0;
        #12;
        chk("rst_valid_a", int'(vao), 0);
        chk("rst_q_a",     int'(qa),  0);
        chk("rst_valid_b", int'(vbo), 0);
        chk("rst_q_b",     int'(qb),  0);
        rst_n = 1'b1;
        tick();

        // Table vectors, random share split, then valid must drop after one cycle
        for (int t = 0; t < 4; t++) begin
            pulse_a(tbl[t].x, tbl[t].b, 2'($urandom), 2'($urandom), qun, vo);
            chk("tbl_valid", int'(vo), 1);
            chk("tbl_q", int'(qun), int'(tbl[t].q));
            tick();
            chk("tbl_valid_drop", int'(vao), 0);
        end

        // All operand pairs under every share split
        for (int x = 0; x < 4; x++)
            for (int b = 0; b < 4; b++)
                for (int rx = 0; rx < 4; rx++)
                    for (int rb = 0; rb < 4; rb++) begin
                        pulse_a(2'(x), 2'(b), 2'(rx), 2'(rb), qun, vo);
                        chk("exh_valid", int'(vo), 1);
                        chk("exh_q", int'(qun), int'(ref_q(2'(x), 2'(b))));
                    end

        // Hold: valid low for 5 cycles with toggling inputs
        pulse_a(2'b01, 2'b11, 2'($urandom), 2'($urandom), qun, vo);
        chk("hold_first_q", int'(qun), int'(ref_q(2'b01, 2'b11)));
        held_a = qa;
        for (int c = 0; c < 5; c++) begin
            xa = 4'($urandom); ba = 4'($urandom); za = 2'($urandom);
            tick();
            chk("hold_valid", int'(vao), 0);
            chk("hold_q", int'(qa), int'(held_a));
        end

        // Lane independence on the 3-share, 2-lane instance
        xb = pack_b(2'b01, 2'b11);
        bb = pack_b(2'b01, 2'b10);
        zb = 12'($urandom);
        pulse_b(qun_b, vo);
        chk("lanes_valid", int'(vo), 1);
        chk("lanes_q", int'(qun_b), int'({2'b01, 2'b10}));

        // Back-to-back stream of 64 random operand pairs
        got = 0;
        for (int k = 0; k < 64 + LATENCY + 2; k++) begin
            if (k < 64) begin
                x0 = 2'($urandom); b0 = 2'($urandom);
                x1 = 2'($urandom); b1 = 2'($urandom);
                xb = pack_b(x0, x1);
                bb = pack_b(b0, b1);
                zb = 12'($urandom);
                vb = 1'b1;
                expq.push_back({ref_q(x1, b1), ref_q(x0, b0)});
            end else begin
                vb = 1'b0;
            end
            tick();
            if (vbo) begin
                if (expq.size() == 0) begin
                    chk("stream_extra_valid", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("stream_q", int'({unsh_b(qb, 1), unsh_b(qb, 0)}), int'(e));
                    got++;
                end
            end
        end
        chk("stream_count", got, 64);

        // Same operands and split, two Z vectors differing in pair 0 of each lane
        xb = pack_b(2'b10, 2'b00);
        bb = pack_b(2'b11, 2'b01);
        z1 = 12'($urandom);
        zb = z1;
        pulse_b(qun_b, vo);
        q1 = qb;
        zb = z1 ^ 12'h041;
        pulse_b(qun_b2, vo);
        q2 = qb;
        chk("z_unshared_q1", int'(qun_b), int'({ref_q(2'b00, 2'b01), ref_q(2'b10, 2'b11)}));
        chk("z_unshared_equal", int'(qun_b2), int'(qun_b));
        chk("z_shares_differ", int'(q1 != q2), 1);

        // Asynchronous reset mid-stream, between clock edges
        for (int k = 0; k < 3; k++) begin
            xb = 12'($urandom); bb = 12'($urandom); zb = 12'($urandom);
            vb = 1'b1;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(vbo), 0);
        chk("midrst_q", int'(qb), 0);
        vb = 1'b0;
        tick();
        chk("inrst_q", int'(qb), 0);
        #2;
        rst_n = 1'b1;
        xb = pack_b(2'b01, 2'b11);
        bb = pack_b(2'b01, 2'b10);
        zb = 12'($urandom);
        vb = 1'b1;
        for (int i = 1; i <= LATENCY; i++) begin
            tick();
            vb = 1'b0;
            chk("postrst_valid", int'(vbo), (i == LATENCY) ? 1 : 0);
        end
        chk("postrst_q", int'({unsh_b(qb, 1), unsh_b(qb, 0)}), int'({2'b01, 2'b10}));
        tick();
        chk("postrst_valid_drop", int'(vbo), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
